comparator_sweep_checker: RTL and testbench
===========================================

Name: comparator_sweep_checker

Overview:
Self-contained sequential driver and checker for the team's combinational magnitude comparators. It generates every (A, B) operand pair and drives it into a comparator under test. It samples the gt/lt/et results and checks them against an internal reference, then reports error count, first failing vector and pass/done status. It sits on the opposite side of the comparator interface: it produces A/B and consumes gt/lt/et. It is used for on-chip self-test and as a reusable bench component.

Parameters:
WIDTH, 2, operand width of A and B in bits (min 1)
SETTLE_CYCLES, 1, cycles each vector is held before the result is sampled (min 1)

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
a_out  output  WIDTH  operand A to comparator under test
b_out  output  WIDTH  operand B to comparator under test
gt_in  input  1  comparator result A>B
lt_in  input  1  comparator result A<B
et_in  input  1  comparator result A==B
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next start or reset
pass  output  1  valid while done=1; 1 iff err_count==0
err_count  output  2*WIDTH+1  number of mismatching vectors
fail_valid  output  1  a first failure has been captured
fail_a  output  WIDTH  A of first failing vector
fail_b  output  WIDTH  B of first failing vector

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low: assertion forces state IDLE immediately, independent of clk.
- Reset values: all outputs 0, index 0, settle counter 0.
- Reset mid-sweep aborts the sweep with no residue. After release the block waits in IDLE for start.
- Vector index idx is 2*WIDTH bits wide, with a_out = idx[2W-1:W] and b_out = idx[W-1:0]. Order is A-major: (0,0),(0,1)..(0,3),(1,0).. for WIDTH=2. There are N = 2^(2*WIDTH) vectors in total.
- All outputs are registered. a_out and b_out change only on the edge that enters DRIVE for a new vector.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE: busy=0, done=0. At the edge where start=1, go to DRIVE with idx=0 and a_out=b_out=0. The same edge clears err_count, fail_valid, fail_a and fail_b, and sets busy=1.
- DRIVE: the vector is held for exactly SETTLE_CYCLES cycles, then the block goes to CHECK.
- CHECK (one cycle): compute the expected triple exp_gt=(A>B), exp_lt=(A<B), exp_et=(A==B), unsigned. A mismatch is any of the three inputs differing from its expected value. This includes multiple-hot or all-zero outputs.
- On a mismatch: err_count increments. If fail_valid=0, set fail_valid=1 and capture fail_a/fail_b from the current vector. Later failures do not overwrite the capture.
- Leaving CHECK: if idx==N-1, go to DONE with busy=0 and done=1. Otherwise increment idx, drive the next vector and return to DRIVE.
- The last vector's mismatch, if any, is already reflected in err_count on the edge done rises.
- Latency: done rises N*(SETTLE_CYCLES+1) edges after the start-accept edge. With defaults this is 32 edges.
- DONE: a_out/b_out hold the last vector. done, pass, err_count and the fail_* outputs remain stable. start=1 restarts exactly as from IDLE.
- start while busy=1 is ignored.
- err_count width holds N without overflow, so no saturation logic is needed.
- pass = done & (err_count==0); it is 0 whenever done=0.

Test Plan:
- Correct 2-bit comparator model attached, start pulsed one cycle -> busy=1 next cycle; done=1 at edge 32; pass=1; err_count=0; fail_valid=0.
- Comparator with gt stuck at 0 -> err_count=6; fail_valid=1; fail_a=1, fail_b=0; pass=0.
- Comparator with et stuck at 1 -> err_count=12; fail_a=0, fail_b=1.
- gt and lt swapped -> err_count=12; first fail (0,1). Then start pulsed again in DONE with the model corrected -> counters cleared, new sweep ends with pass=1.
- rst_n asserted asynchronously while idx=5 (a_out=1, b_out=1) -> all outputs 0 immediately. start pulses during busy of a subsequent sweep are ignored; done still rises at edge 32.
- SETTLE_CYCLES=3, WIDTH=2, correct model -> each vector held 3 cycles before check; done at edge 64; pass=1.

Source files
------------

// File: rtl/comparator_sweep_checker.sv
// Exhaustive sweep driver/checker for a combinational magnitude comparator.
// Walks every (A,B) pair A-major, checks gt/lt/et, and records the error count and first failure.
module comparator_sweep_checker #(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic               gt_in,
    input  logic               lt_in,
    input  logic               et_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);
    localparam int IW = 2 * WIDTH;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            settled;
    logic            last;
    logic            mismatch;
    logic [2*WIDTH:0] err_nxt;

    // Operands come straight from the registered index, so they are registered outputs.
    assign a_out    = idx[IW-1:WIDTH];
    assign b_out    = idx[WIDTH-1:0];
    assign settled  = (cnt == CW'(SETTLE_CYCLES - 1));
    assign last     = &idx;
    assign mismatch = (gt_in != (a_out > b_out)) |
                      (lt_in != (a_out < b_out)) |
                      (et_in != (a_out == b_out));
    assign err_nxt  = err_count + {{(2*WIDTH){1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      if (settled) state_nxt = CHECK;
            CHECK:      state_nxt = last ? DONE : DRIVE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx        <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                    end
                end
                DRIVE: cnt <= settled ? '0 : cnt + CW'(1);
                CHECK: begin
                    err_count <= err_nxt;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a_out;
                        fail_b     <= b_out;
                    end
                    // Pass is decided from err_nxt so the final vector counts on the done edge.
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_nxt == '0);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Randomized/directed bench for comparator_sweep_checker with fault-injecting comparator models.
// A reference sweep over all pairs predicts error count and first failure for each run.
module tb_comparator_sweep_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] a_out, b_out;
    logic       gt_in, lt_in, et_in;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [1:0] fail_a, fail_b;

    logic       start3 = 1'b0;
    logic [1:0] a3, b3, fa3, fb3;
    logic       busy3, done3, pass3, fv3;
    logic [4:0] err3;

    int         mode = 0;
    logic [2:0] xmask [16];
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    comparator_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out),
        .gt_in(gt_in), .lt_in(lt_in), .et_in(et_in), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_valid(fail_valid),
        .fail_a(fail_a), .fail_b(fail_b)
    );

    comparator_sweep_checker #(.WIDTH(2), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a3), .b_out(b3),
        .gt_in(a3 > b3), .lt_in(a3 < b3), .et_in(a3 == b3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
    );

    // Comparator under test: a correct comparator with a selectable fault.
    function automatic logic [2:0] cmp_model(input int m, input logic [1:0] a, input logic [1:0] b);
        logic [2:0] good;
        good = {a > b, a < b, a == b};
        case (m)
            1:       return {1'b0, good[1:0]};
            2:       return {good[2:1], 1'b1};
            3:       return {good[1], good[2], good[0]};
            4:       return good ^ xmask[{a, b}];
            default: return good;
        endcase
    endfunction

    always_comb {gt_in, lt_in, et_in} = cmp_model(mode, a_out, b_out);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic ref_sweep(input int m, output int errs, output bit fv, output int fa, output int fb);
        errs = 0; fv = 0; fa = 0; fb = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                logic [2:0] r;
                r = cmp_model(m, a[1:0], b[1:0]);
                if (r[2] != (a > b) || r[1] != (a < b) || r[0] != (a == b)) begin
                    errs++;
                    if (!fv) begin fv = 1; fa = a; fb = b; end
                end
            end
    endtask

    task automatic run_sweep(input int m, input bit noise);
        int errs, fa, fb, edges;
        bit fv;
        @(negedge clk);
        mode = m;
        ref_sweep(m, errs, fv, fa, fb);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err_count, 0);
        chk("fail_cleared", fail_valid, 0);
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            start = (noise && edges < 20) ? 1'($urandom) : 1'b0;
        end
        start = 1'b0;
        chk("done_edge", edges, 32);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("pass", pass, errs == 0);
        chk("err_count", err_count, errs);
        chk("fail_valid", fail_valid, fv);
        chk("fail_a", fail_a, fv ? fa : 0);
        chk("fail_b", fail_b, fv ? fb : 0);
        chk("last_vec", {a_out, b_out}, 4'hF);
        repeat (3) @(posedge clk);
        #1 chk("done_hold", {done, pass, err_count}, {1'b1, errs == 0, 5'(errs)});
    endtask

    initial begin
        int edges, first_b;
        #2 chk("reset_state", {busy, done, pass, err_count, fail_valid, fail_a, fail_b, a_out, b_out}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_wait", busy, 0);

        run_sweep(0, 0);
        run_sweep(1, 0);
        run_sweep(2, 0);
        run_sweep(3, 0);
        run_sweep(0, 0);  // restart from DONE with corrected model

        // Async reset mid-sweep at idx 5 with an error already recorded.
        @(negedge clk);
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("idx5_vec", {a_out, b_out}, 4'b0101);
        chk("err_before_rst", err_count, 1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst", {busy, done, pass, err_count, fail_valid, fail_a, fail_b, a_out, b_out}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_after_rst", {busy, done}, 0);

        run_sweep(0, 1);  // start noise during busy
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) xmask[i] = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b0;
            run_sweep(4, k[0]);
        end

        // Longer settle time on the second instance.
        @(negedge clk) start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        edges = 0; first_b = -1;
        while (!done3 && edges < 300) begin
            @(posedge clk); #1;
            edges++;
            if (first_b < 0 && b3 == 2'd1) first_b = edges;
        end
        chk("s3_hold", first_b, 4);
        chk("s3_done_edge", edges, 64);
        chk("s3_pass", {pass3, err3, fv3}, {1'b1, 5'd0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
